rand_server: RTL and testbench
==============================

# rand_server

Shared pseudo-random number server for the game logic. Alien-shot scheduling, UFO spawn and similar consumers each need bounded random values. This block owns one free-running Galois LFSR and arbitrates round-robin among `N_REQ` requesters. For each grant it returns one value uniformly reduced to the range `[0, limit)` that the requester supplied.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `LEN`, 16, LFSR width
- `TAPS`, 16'hB400, Galois feedback mask XORed in when the shifted-out bit is 1
- `SEED`, 16'hACE1, LFSR value loaded at reset; a value of 0 is replaced by 1
- `OUT_W`, 8, result width (OUT_W ≤ LEN)
- `MAX_TRY`, 4, rejection-sampling attempts before fallback (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  level request, one bit per requester
- `limit`  in  N_REQ*OUT_W  per-requester exclusive upper bound; slice i = `limit[i*OUT_W +: OUT_W]`; 0 means full range
- `ack`  out  N_REQ  one-cycle pulse to the serviced requester
- `rnd_data`  out  OUT_W  result, valid in the `ack` cycle, held until the next `ack`
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- LFSR: advances every cycle, regardless of state: `lfsr <= {1'b0, lfsr[LEN-1:1]} ^ (lfsr[0] ? TAPS : 0)`. Reset loads `SEED`, or 1 if `SEED` is 0.
- FSM states: IDLE, LOAD, DRAW, RESP.
- IDLE:
  - If `req` ≠ 0, grant the first set bit at or after `ptr`, wrapping around.
  - Latch grant index `g` and `lim = limit[g]`, then go to LOAD.
  - `ptr` resets to 0.
- LOAD:
  - Register `mask` = smallest 2^k−1 ≥ `lim`−1. For `lim` = 0 the mask is all ones; for `lim` = 1 it is 0.
  - Clear try counter `t`, then go to DRAW.
- DRAW:
  - `v = lfsr[OUT_W-1:0] & mask`.
  - If `lim` = 0 or `v < lim`: `rnd_data <= v`, go to RESP.
  - Else if `t == MAX_TRY-1`: `rnd_data <= v − lim` (always valid, because `mask < 2*lim`), go to RESP.
  - Else `t <= t+1` and stay in DRAW. The next DRAW sees the advanced LFSR.
- RESP:
  - `ack[g]` = 1 for exactly this cycle.
  - `ptr <= (g+1) mod N_REQ`, go to IDLE.
- Requester rules:
  - Hold `limit[i]` stable while `req[i]` is high.
  - Drop `req[i]` in the cycle after `ack[i]`. If it is still high in IDLE, it is a new request that competes under the updated `ptr`.
- `req` deasserted before grant: no service.
- `req` deasserted after grant: service completes and `ack` still pulses.
- `limit` changes after the IDLE latch are ignored for the current service.
- Only one requester is serviced at a time, and `ack` is one-hot or zero.
- Reset at any point:
  - State goes to IDLE, `ptr` to 0, `ack` to 0, `rnd_data` to 0, `busy` to 0, `lfsr` to the seed.
  - An in-flight service is dropped with no `ack`.

## Timing
- Request seen in IDLE at edge t gives LOAD at t+1, DRAW at t+2, and `ack` plus `rnd_data` in the cycle after the accepting DRAW edge.
  - Minimum latency is 3 cycles from request sample to `ack`.
  - Maximum is 2+MAX_TRY cycles.
- Minimum service period is 4 cycles per grant (IDLE, LOAD, DRAW, RESP).
- `busy` rises the cycle after the grant decision and falls when returning to IDLE.
- With all requesters continuously requesting, each waits at most N_REQ services.
- Reset values: `ack` = 0, `rnd_data` = 0, `busy` = 0.

## Test plan
- **Reset:** hold `rst` = 0, release.
  - Required: `ack` = 0, `rnd_data` = 0, `busy` = 0.
  - Internal `lfsr` = 16'hACE1; after one clock it is 16'h5670 ^ 16'hB400 = 16'hE270.
  - Repeat with `SEED` = 0: `lfsr` = 1 after reset.
- **Single request, `limit[0]` = 10:**
  - Required: `ack[0]` pulses once, 3 to 6 cycles after `req` is sampled.
  - `rnd_data` < 10 and equal to the bench LFSR model's reduced value.
- **Bounds, full range (`limit` = 0):** `rnd_data` equals `lfsr[7:0]` in the DRAW cycle, with `ack` at exactly +3.
- **Bounds, `limit` = 1:** `rnd_data` = 0.
- **Bounds, `limit` = 129:** force the maximum retries via the model and check fallback `rnd_data` = v − 129 < 129.
- **Fairness:** hold `req` = 4'b1111 (each requester re-asserts immediately).
  - Required: `ack` order 0,1,2,3,0,1, one grant every 4+ cycles.
  - `ack` is never multi-hot.
- **Mid-operation events:**
  - Drop `req[2]` during LOAD: `ack[2]` still pulses.
  - Assert `rst` = 0 during DRAW: no `ack`, `busy` = 0 immediately, and the next request is serviced starting from `ptr` = 0.

Source files
------------

// File: rtl/rand_server.sv
// rand_server: one free-running Galois LFSR shared round-robin among requesters,
// each grant returning a value reduced to [0, limit) by bounded rejection sampling.
module rand_server #(
  parameter int N_REQ = 4,
  parameter int LEN = 16,
  parameter logic [LEN-1:0] TAPS = 16'hB400,
  parameter logic [LEN-1:0] SEED = 16'hACE1,
  parameter int OUT_W = 8,
  parameter int MAX_TRY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*OUT_W-1:0] limit,
  output logic [N_REQ-1:0]       ack,
  output logic [OUT_W-1:0]       rnd_data,
  output logic                   busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(MAX_TRY + 1);
  localparam logic [LEN-1:0] SEED0 = (SEED == '0) ? LEN'(1) : SEED;
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, RESP} state_t;
  state_t state, state_nx;
  logic [LEN-1:0] lfsr;
  logic [IW-1:0] ptr, g, g_nx;
  logic [OUT_W-1:0] lim, mask, mask_nx, v;
  logic [TW-1:0] t;
  logic hit, ok, last;
  int j;
  // Scan downward so the requester closest at/after ptr is the last writer and wins.
  always_comb begin
    g_nx = ptr;
    hit = 1'b0;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        g_nx = IW'(j);
        hit = 1'b1;
      end
    end
  end
  // Smearing lim-1 rightward gives the smallest 2^k-1 covering it; lim=0 wraps to all ones.
  always_comb begin
    mask_nx = lim - OUT_W'(1);
    for (int i = 1; i < OUT_W; i++) mask_nx = mask_nx | (mask_nx >> i);
  end
  assign v = lfsr[OUT_W-1:0] & mask;
  assign ok = (lim == '0) || (v < lim);
  assign last = t == TW'(MAX_TRY - 1);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = hit ? LOAD : IDLE;
      LOAD: state_nx = DRAW;
      DRAW: state_nx = (ok || last) ? RESP : DRAW;
      RESP: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lfsr <= SEED0;
      ptr <= '0;
      g <= '0;
      lim <= '0;
      mask <= '0;
      t <= '0;
      rnd_data <= '0;
    end else begin
      state <= state_nx;
      lfsr <= {1'b0, lfsr[LEN-1:1]} ^ (lfsr[0] ? TAPS : '0);
      if (state == IDLE && hit) begin
        g <= g_nx;
        lim <= limit[g_nx*OUT_W +: OUT_W];
      end
      if (state == LOAD) begin
        mask <= mask_nx;
        t <= '0;
      end
      if (state == DRAW) begin
        if (ok) rnd_data <= v;
        else if (last) rnd_data <= v - lim;
        else t <= t + TW'(1);
      end
      if (state == RESP) ptr <= (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
    end
  end
  assign ack = (state == RESP) ? (N_REQ'(1) << g) : '0;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_rand_server.sv
// tb_rand_server: vector table plus scoreboard of model-predicted grants for rand_server.
module tb_rand_server;
  localparam int N = 4, W = 8, MT = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0, zreq = '0;
  logic [N*W-1:0] limit = '0, zlim = '0;
  logic [N-1:0] ack, ack1;
  logic [W-1:0] rnd_data, rnd1;
  logic busy, busy1;
  rand_server dut (.clk(clk), .rst(rst), .req(req), .limit(limit), .ack(ack), .rnd_data(rnd_data), .busy(busy));
  rand_server #(.SEED(16'h0000)) u1 (.clk(clk), .rst(rst), .req(zreq), .limit(zlim), .ack(ack1), .rnd_data(rnd1), .busy(busy1));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [15:0] step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= step(m_lfsr);
  typedef struct {int idx; logic [7:0] data; int lat;} exp_t;
  typedef struct {int idx; logic [7:0] lim; int drop_at; int max_lat;} vec_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // l is the LFSR value the DUT samples at the grant edge; draws begin two steps later.
  function automatic exp_t predict(input int idx, input logic [15:0] l, input logic [7:0] lim);
    exp_t e;
    logic [7:0] mask, v;
    mask = 8'hFF;
    if (lim != 8'd0) begin
      mask = 8'h00;
      while (mask < lim - 8'd1) mask = {mask[6:0], 1'b1};
    end
    e.idx = idx;
    e.data = 8'h00;
    e.lat = 0;
    l = step(step(l));
    for (int t = 0; t < MT; t++) begin
      v = l[7:0] & mask;
      if (lim == 8'd0 || v < lim) begin
        e.data = v;
        e.lat = 3 + t;
        return e;
      end
      if (t == MT - 1) begin
        e.data = v - lim;
        e.lat = 3 + t;
        return e;
      end
      l = step(l);
    end
    return e;
  endfunction
  task automatic wait_check(input logic [7:0] lim, input int drop_idx, input int drop_at, input int max_lat);
    exp_t e;
    int cnt;
    cnt = 0;
    while (cnt < 20 && ack == '0) begin
      @(negedge clk);
      cnt++;
      if (cnt == drop_at) req[drop_idx] = 1'b0;
    end
    e = sb.pop_front();
    if (ack == '0) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: no ack after %0d cycles, expected ack[%0d]", cnt, e.idx);
      return;
    end
    req = req & ~ack;
    check("ack_idx", 32'(ack), 32'(1 << e.idx));
    check("data", 32'(rnd_data), 32'(e.data));
    check("latency", cnt, e.lat);
    check("lat_max", 32'(cnt <= max_lat), 1);
    check("bound", 32'(lim == 8'd0 || rnd_data < lim), 1);
    @(negedge clk);
    check("ack_pulse", 32'(ack), 0);
    check("hold", 32'(rnd_data), 32'(e.data));
    check("busy_idle", 32'(busy), 0);
  endtask
  task automatic serve(input int idx, input logic [7:0] lim, input int drop_at, input int max_lat);
    limit[idx*W +: W] = lim;
    req[idx] = 1'b1;
    sb.push_back(predict(idx, m_lfsr, lim));
    wait_check(lim, idx, drop_at, max_lat);
  endtask
  initial begin
    vec_t tbl[8];
    exp_t e;
    int found, n, cyc, lastc;
    int order[6];
    logic [15:0] pl;
    logic quiet;
    tbl = '{'{0, 8'd10, 0, 6}, '{1, 8'd0, 0, 3}, '{2, 8'd1, 0, 3}, '{3, 8'd200, 0, 6},
            '{0, 8'd255, 0, 6}, '{1, 8'd2, 0, 6}, '{2, 8'd50, 1, 6}, '{3, 8'd128, 0, 6}};
    order = '{0, 1, 2, 3, 0, 1};
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_rnd", 32'(rnd_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
    check("rst_lfsr_seed0", 32'(u1.lfsr), 1);
    rst = 1'b1;
    @(negedge clk);
    check("lfsr_step1", 32'(dut.lfsr), 32'h0000E270);
    for (int i = 0; i < 8; i++) serve(tbl[i].idx, tbl[i].lim, tbl[i].drop_at, tbl[i].max_lat);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      e = predict(0, m_lfsr, 8'd129);
      if (e.lat == 2 + MT) found = 1;
      else @(negedge clk);
    end
    check("fallback_found", found, 1);
    if (found == 1) serve(0, 8'd129, 0, 2 + MT);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    limit = '0;
    req = 4'b1111;
    n = 0;
    cyc = 0;
    lastc = -100;
    pl = m_lfsr;
    while (n < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        check("fair_idx", 32'(ack), 32'(1 << order[n]));
        check("fair_onehot", 32'($onehot(ack)), 1);
        check("fair_data", 32'(rnd_data), 32'(pl[7:0]));
        if (n > 0) check("fair_gap", 32'(cyc - lastc >= 4), 1);
        lastc = cyc;
        n++;
      end
      pl = m_lfsr;
    end
    req = '0;
    check("fair_count", n, 6);
    @(negedge clk);
    serve(1, 8'd0, 0, 3);
    limit = '0;
    req[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("draw_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("rst_busy_now", 32'(busy), 0);
    check("rst_ack_now", 32'(ack), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ack != '0) quiet = 1'b0;
    end
    check("dropped_no_ack", 32'(quiet), 1);
    req = 4'b1001;
    sb.push_back(predict(0, m_lfsr, 8'd0));
    wait_check(8'd0, 0, 0, 3);
    sb.push_back(predict(3, m_lfsr, 8'd0));
    wait_check(8'd0, 3, 0, 3);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
